// File: rtl/game_pkg.sv
// Shared state encoding for the game round controller, score counter and display mux.
package game_pkg;

  localparam int FSM_STATE_W = 3;

  localparam logic [FSM_STATE_W-1:0] IDLE      = 3'd0;
  localparam logic [FSM_STATE_W-1:0] RUNNING   = 3'd1;
  localparam logic [FSM_STATE_W-1:0] FINISH    = 3'd2;
  localparam logic [FSM_STATE_W-1:0] ROUND_END = 3'd3;
  localparam logic [FSM_STATE_W-1:0] PAUSED    = 3'd4;

  typedef enum logic [FSM_STATE_W-1:0] {
    S_IDLE      = IDLE,
    S_RUNNING   = RUNNING,
    S_FINISH    = FINISH,
    S_ROUND_END = ROUND_END,
    S_PAUSED    = PAUSED
  } game_state_e;

endpackage

// File: rtl/sec_tick_gen.sv
// One-second prescaler: counts 0..CLK_HZ-1 while run is high and emits a
// one-cycle tick at terminal count; holds its count while run is low.
module sec_tick_gen #(
  parameter int CLK_HZ = 100000000
) (
  input  logic clkIn,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);

  // CLK_HZ=1 would give a zero-width counter; keep at least one bit.
  localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0] TERM_CNT = PRE_W'(CLK_HZ - 1);

  logic [PRE_W-1:0] cnt_reg;

  assign tick = run & (cnt_reg == TERM_CNT);

  always_ff @(posedge clkIn or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (run) begin
      cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/game_round_ctrl.sv
// Multi-round game controller with per-round countdown and optional pause.
// Optional pause support is enabled by defining GAME_PAUSE_EN.
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int  CLK_HZ     = 100000000,
  parameter int  ROUND_SEC  = 30,
  parameter int  NUM_ROUNDS = 3,
  localparam int TIME_W     = $clog2(ROUND_SEC + 1),
  localparam int ROUND_W    = $clog2(NUM_ROUNDS + 1)
) (
  input  logic                   clkIn,
  input  logic                   reset,
  input  logic                   startGame,
  input  logic                   pause,
  output logic                   game_active,
  output logic [FSM_STATE_W-1:0] fsm_state,
  output logic [TIME_W-1:0]      time_left,
  output logic [ROUND_W-1:0]     round_num,
  output logic                   round_done,
  output logic                   game_done
);

  localparam logic [TIME_W-1:0]  TIME_INIT = TIME_W'(ROUND_SEC);
  localparam logic [ROUND_W-1:0] LAST_RND  = ROUND_W'(NUM_ROUNDS);

  game_state_e        state_reg, state_next;
  logic [TIME_W-1:0]  time_left_reg, time_left_next;
  logic [ROUND_W-1:0] round_num_reg, round_num_next;
  logic               round_done_reg, round_done_next;
  logic               game_done_reg, game_done_next;
  logic               game_active_reg;
  logic               start_q_reg;
  logic               start_rise;
  logic               pause_rise;
  logic               tick_run, tick_clear, sec_tick;

  assign start_rise = startGame & ~start_q_reg;

`ifdef GAME_PAUSE_EN
  logic pause_q_reg;

  always_ff @(posedge clkIn or negedge reset) begin
    if (!reset) begin
      pause_q_reg <= 1'b0;
    end else begin
      pause_q_reg <= pause;
    end
  end

  assign pause_rise = pause & ~pause_q_reg;
`else
  logic unused_pause;

  assign unused_pause = pause;
  assign pause_rise   = 1'b0;
`endif

  sec_tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_sec_tick (
    .clkIn (clkIn),
    .reset (reset),
    .run   (tick_run),
    .clear (tick_clear),
    .tick  (sec_tick)
  );

  always_comb begin
    state_next      = state_reg;
    time_left_next  = time_left_reg;
    round_num_next  = round_num_reg;
    round_done_next = 1'b0;
    game_done_next  = 1'b0;
    tick_run        = 1'b0;
    tick_clear      = 1'b0;

    case (state_reg)
      S_IDLE, S_FINISH, S_ROUND_END: begin
        if (start_rise) begin
          state_next     = S_RUNNING;
          time_left_next = TIME_INIT;
          tick_clear     = 1'b1;
          round_num_next = (state_reg == S_ROUND_END) ? round_num_reg + 1'b1
                                                      : ROUND_W'(1);
        end
      end

      S_RUNNING: begin
        tick_run = 1'b1;
        // Expiry takes priority over a pause edge in the same cycle.
        if (sec_tick && (time_left_reg <= TIME_W'(1))) begin
          time_left_next  = '0;
          round_done_next = 1'b1;
          if (round_num_reg < LAST_RND) begin
            state_next = S_ROUND_END;
          end else begin
            state_next     = S_FINISH;
            game_done_next = 1'b1;
          end
        end else begin
          if (sec_tick) begin
            time_left_next = time_left_reg - 1'b1;
          end
          if (pause_rise) begin
            state_next = S_PAUSED;
          end
        end
      end

`ifdef GAME_PAUSE_EN
      S_PAUSED: begin
        if (pause_rise) begin
          state_next = S_RUNNING;
        end
      end
`endif

      default: begin
        state_next     = S_IDLE;
        time_left_next = TIME_INIT;
        round_num_next = '0;
        tick_clear     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clkIn or negedge reset) begin
    if (!reset) begin
      state_reg       <= S_IDLE;
      time_left_reg   <= TIME_INIT;
      round_num_reg   <= '0;
      round_done_reg  <= 1'b0;
      game_done_reg   <= 1'b0;
      game_active_reg <= 1'b0;
      start_q_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      time_left_reg   <= time_left_next;
      round_num_reg   <= round_num_next;
      round_done_reg  <= round_done_next;
      game_done_reg   <= game_done_next;
      game_active_reg <= (state_next == S_RUNNING);
      start_q_reg     <= startGame;
    end
  end

  assign fsm_state   = state_reg;
  assign game_active = game_active_reg;
  assign time_left   = time_left_reg;
  assign round_num   = round_num_reg;
  assign round_done  = round_done_reg;
  assign game_done   = game_done_reg;

endmodule
